adc_capture: RTL
================

// Module: adc_capture
// PURPOSE
//  Receive-side counterpart of the DAC waveform path. Takes the 256-bit ADC sample stream from
//  the RFSoC IP, captures a programmable-length record into on-chip RAM on a qualified trigger,
//  then streams the record to the PS over AXI-Stream with TLAST. The ADC side is never stalled.
// PARAMETERS
//  mem_width  10  log2 of capture RAM depth in 256-bit words (DEPTH = 2**mem_width); legal range 2..12
// PORTS
//  clk            in   1    single clock for all logic
//  rst            in   1    asynchronous, active-high reset
//  gpio_ctrl      in   16   [0] arm (rising edge); [1] select gate enable; [2] abort (level); [3] rsvd; [15:4] length L (words)
//  s_axis_tdata   in   256  ADC samples from RFSoC IP
//  s_axis_tvalid  in   1    ADC sample valid
//  s_axis_tready  out  1    to RFSoC IP; 1 in every state once out of reset
//  m_axis_tdata   out  256  captured record to PS
//  m_axis_tvalid  out  1    record word valid
//  m_axis_tready  in   1    PS ready
//  m_axis_tlast   out  1    high on the record's final word
//  trigger_in     in   1    capture trigger (rising edge, already in clk domain)
//  select_in      in   1    channel select qualifier for trigger
//  capture_busy   out  1    high in ARMED, CAPTURE, READOUT
//  capture_done   out  1    sticky: set on final READOUT handshake; cleared by the next accepted arm
//  gap_err        out  1    sticky: s_axis_tvalid low during a CAPTURE cycle; cleared by the next accepted arm
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0 (s_axis_tready rises 1 cycle after rst deasserts); pointers, flags, edge regs 0.
//  Edge detect: arm_edge = gpio_ctrl[0] & ~prev; trig_edge = trigger_in & ~prev; prev regs updated every cycle.
//  Length: Leff = min(L, DEPTH), latched when the arm is accepted; L==0 -> arm ignored (stay IDLE).
//  FSM:
//   IDLE    : arm_edge & L!=0 -> ARMED; latch Leff; clear done/gap_err; wr_ptr=rd_ptr=0.
//   ARMED   : trig_edge & (select_in | ~gpio_ctrl[1]) -> CAPTURE. Unqualified triggers ignored.
//             A trigger in the same cycle as the arm is not seen (needs a new edge while ARMED).
//   CAPTURE : first eligible beat is the cycle after entry. Each cycle with s_axis_tvalid: RAM[wr_ptr]<=tdata, wr_ptr++.
//             Cycle with tvalid=0: no write; gap_err<=1. On the write of word Leff-1 -> READOUT.
//   READOUT : words 0..Leff-1 in order; 1-cycle RAM read latency hidden by prefetch/skid reg.
//             First m_axis_tvalid <=2 cycles after READOUT entry. Standard AXIS: tdata/tlast stable while tvalid & ~tready.
//             No bubbles when tready is held 1. tlast only on word Leff-1. Its handshake -> IDLE, done<=1, tvalid<=0 the next cycle.
//  Abort: gpio_ctrl[2]=1 in any state -> IDLE next cycle; pointers 0; m_axis_tvalid/tlast 0; done not set.
//         Abort beats arm in the same cycle. Abort is the only legal mid-stream drop of tvalid.
//  Triggers and arm edges during CAPTURE/READOUT: ignored. Changes to gpio_ctrl[15:4] after arm: ignored.
//  Pointers are mem_width+1 bits; no wrap in one record (Leff<=DEPTH); ADC data outside CAPTURE is discarded.
//  Async reset mid-operation: immediate return to reset values; no partial record is emitted afterwards.
// TESTING
//  1 mem_width=10, L=4, arm, trigger, ADC words 0x1..0x8 with tvalid=1 -> m_axis emits 0x1,0x2,0x3,0x4 (tlast on 0x4); done=1, busy=0, gap_err=0.
//  2 L=64; m_axis_tready toggles 1-0 every cycle -> 64 words in order, no drops or dups, tdata stable while stalled, single tlast.
//  3 gpio_ctrl[1]=1, select_in=0, trigger pulse -> stays ARMED, no writes; then select_in=1 plus trigger -> capture proceeds.
//  4 L=0 plus arm -> busy stays 0. mem_width=4, L=20 -> exactly 16 words out, tlast on word 15.
//  5 L=8 with s_axis_tvalid low for 2 cycles mid-capture -> gap_err=1; 8 valid words still delivered in order.
//  6 Abort at capture word 3 -> IDLE next cycle, busy=0, done=0, no m_axis output. rst mid-READOUT -> all outputs 0 at once.

Source files
------------

// File: rtl/adc_capture.sv
// adc_capture: arm/trigger-qualified capture of the 256-bit ADC stream into on-chip RAM,
// followed by an AXI-Stream readout of the record with TLAST on the final word.
module adc_capture #(
  parameter int unsigned mem_width = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [15:0]  gpio_ctrl,
  input  logic [255:0] s_axis_tdata,
  input  logic         s_axis_tvalid,
  output logic         s_axis_tready,
  output logic [255:0] m_axis_tdata,
  output logic         m_axis_tvalid,
  input  logic         m_axis_tready,
  output logic         m_axis_tlast,
  input  logic         trigger_in,
  input  logic         select_in,
  output logic         capture_busy,
  output logic         capture_done,
  output logic         gap_err
);

  localparam int unsigned DW    = 256;
  localparam int unsigned DEPTH = 32'd1 << mem_width;
  localparam int unsigned PW    = mem_width + 1;
  localparam int unsigned LW    = 12;
  localparam int unsigned LXW   = LW + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    READOUT = 2'd3
  } state_t;

  state_t          state;
  logic            arm_prev;
  logic            trig_prev;
  logic [PW-1:0]   len;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;

  logic [DW-1:0]   mem [DEPTH];
  logic [DW-1:0]   ram_q;

  // Read pipeline: a read issued last cycle lands in ram_q this cycle (pend)
  logic            pend;
  logic            pend_last;
  logic [DW-1:0]   sk_data;
  logic            sk_valid;
  logic            sk_last;

  logic            arm_edge_c;
  logic            trig_edge_c;
  logic            trig_ok_c;
  logic            abort_c;
  logic [LW-1:0]   l_field_c;
  logic [PW-1:0]   leff_c;
  logic            pop_c;
  logic [1:0]      occ_c;
  logic            issue_c;
  logic            wr_fire_c;
  logic            last_wr_c;
  logic            rd_last_c;
  logic            rsvd_unused;

  assign rsvd_unused = gpio_ctrl[3];

  // Control decode, length clamp and readout-pipeline flow control
  always_comb begin
    arm_edge_c  = gpio_ctrl[0] & ~arm_prev;
    trig_edge_c = trigger_in & ~trig_prev;
    trig_ok_c   = trig_edge_c & (select_in | ~gpio_ctrl[1]);
    abort_c     = gpio_ctrl[2];
    l_field_c   = gpio_ctrl[15:4];
    leff_c      = PW'(l_field_c);
    if ({1'b0, l_field_c} > LXW'(DEPTH)) begin
      leff_c = PW'(DEPTH);
    end
    pop_c     = m_axis_tvalid & m_axis_tready;
    // Words held after this cycle's pop; a new read is issued only if it will have a slot
    occ_c     = 2'(m_axis_tvalid) + 2'(sk_valid) - 2'(pop_c);
    issue_c   = (state == READOUT) && (rd_ptr < len) && ((occ_c + 2'(pend)) < 2'd2);
    wr_fire_c = (state == CAPTURE) && s_axis_tvalid && !abort_c;
    last_wr_c = (wr_ptr == len - PW'(1));
    rd_last_c = (rd_ptr == len - PW'(1));
  end

  // Capture RAM: one write port (CAPTURE) and one registered read port (READOUT)
  always_ff @(posedge clk) begin
    if (wr_fire_c) begin
      mem[wr_ptr[mem_width-1:0]] <= s_axis_tdata;
    end
    if (issue_c) begin
      ram_q <= mem[rd_ptr[mem_width-1:0]];
    end
  end

  // Capture/readout FSM with registered outputs and skid-buffered AXIS master
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      arm_prev      <= 1'b0;
      trig_prev     <= 1'b0;
      len           <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      pend          <= 1'b0;
      pend_last     <= 1'b0;
      sk_data       <= '0;
      sk_valid      <= 1'b0;
      sk_last       <= 1'b0;
      s_axis_tready <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      capture_busy  <= 1'b0;
      capture_done  <= 1'b0;
      gap_err       <= 1'b0;
    end else begin
      arm_prev      <= gpio_ctrl[0];
      trig_prev     <= trigger_in;
      s_axis_tready <= 1'b1;
      pend          <= 1'b0;
      pend_last     <= 1'b0;

      if (abort_c) begin
        // Abort wins over everything, including a same-cycle arm
        state         <= IDLE;
        wr_ptr        <= '0;
        rd_ptr        <= '0;
        sk_valid      <= 1'b0;
        sk_last       <= 1'b0;
        m_axis_tvalid <= 1'b0;
        m_axis_tlast  <= 1'b0;
        capture_busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (arm_edge_c && (l_field_c != '0)) begin
              state        <= ARMED;
              len          <= leff_c;
              wr_ptr       <= '0;
              rd_ptr       <= '0;
              capture_busy <= 1'b1;
              capture_done <= 1'b0;
              gap_err      <= 1'b0;
            end
          end

          ARMED: begin
            if (trig_ok_c) begin
              state <= CAPTURE;
            end
          end

          CAPTURE: begin
            if (s_axis_tvalid) begin
              wr_ptr <= wr_ptr + PW'(1);
              if (last_wr_c) begin
                state <= READOUT;
              end
            end else begin
              gap_err <= 1'b1;
            end
          end

          READOUT: begin
            pend      <= issue_c;
            pend_last <= issue_c & rd_last_c;
            if (issue_c) begin
              rd_ptr <= rd_ptr + PW'(1);
            end

            // Output register refills from the skid reg first, then from RAM data
            if (pop_c) begin
              if (sk_valid) begin
                m_axis_tdata  <= sk_data;
                m_axis_tlast  <= sk_last;
                m_axis_tvalid <= 1'b1;
                sk_valid      <= pend;
                sk_last       <= pend & pend_last;
                if (pend) begin
                  sk_data <= ram_q;
                end
              end else if (pend) begin
                m_axis_tdata  <= ram_q;
                m_axis_tlast  <= pend_last;
                m_axis_tvalid <= 1'b1;
              end else begin
                m_axis_tvalid <= 1'b0;
                m_axis_tlast  <= 1'b0;
              end
            end else if (!m_axis_tvalid) begin
              if (pend) begin
                m_axis_tdata  <= ram_q;
                m_axis_tlast  <= pend_last;
                m_axis_tvalid <= 1'b1;
              end
            end else if (pend) begin
              sk_data  <= ram_q;
              sk_last  <= pend_last;
              sk_valid <= 1'b1;
            end

            if (pop_c && m_axis_tlast) begin
              state         <= IDLE;
              capture_done  <= 1'b1;
              capture_busy  <= 1'b0;
              m_axis_tvalid <= 1'b0;
              m_axis_tlast  <= 1'b0;
              sk_valid      <= 1'b0;
              sk_last       <= 1'b0;
              wr_ptr        <= '0;
              rd_ptr        <= '0;
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
